// File: rtl/conv_frame_sched.sv
// Frame sequencer for the 8x8 / 3x3 convolution engine: streams 64 pixels in,
// waits for the output phase, stores 36 results and reports done or err.
module conv_frame_sched #(
  parameter int ADDR_W   = 10,
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 0,
  parameter int TIMEOUT  = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       frame_cnt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              eng_in_st,
  output logic [7:0]        eng_din,
  output logic              eng_din_vld,
  input  logic [15:0]       eng_dout,
  input  logic              eng_out_st,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;

  localparam int              TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   WAIT_LAST = TW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] IN_ADDR0  = ADDR_W'(IN_BASE);
  localparam logic [ADDR_W-1:0] OUT_ADDR0 = ADDR_W'(OUT_BASE);
  // LOAD covers 64 reads plus the two-cycle RAM-to-engine pixel pipeline.
  localparam logic [6:0]      LOAD_LAST = 7'd65;
  localparam logic [5:0]      RES_LAST  = 6'd35;

  logic [2:0]        state_reg, state_next;
  logic [6:0]        k_reg;
  logic [5:0]        j_reg;
  logic [TW-1:0]     wait_cnt_reg;
  logic              rd_vld_reg;
  logic [7:0]        eng_din_reg;
  logic              eng_din_vld_reg;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [15:0]       wr_data_reg;
  logic              done_reg;
  logic              err_reg;
  logic [15:0]       frame_cnt_reg;

  logic load_rd;
  logic wait_timeout;
  logic drain_short;
  logic sample;

  assign load_rd      = (state_reg == LOAD) && !k_reg[6];
  assign wait_timeout = (state_reg == WAIT) && !eng_out_st && (wait_cnt_reg == WAIT_LAST);
  assign drain_short  = (state_reg == DRAIN) && !eng_out_st;
  // The WAIT cycle that sees eng_out_st already carries result 0.
  assign sample       = eng_out_st && ((state_reg == WAIT) || (state_reg == DRAIN));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (k_reg == LOAD_LAST) state_next = WAIT;
      WAIT: begin
        if (eng_out_st)
          state_next = DRAIN;
        else if (wait_cnt_reg == WAIT_LAST)
          state_next = IDLE;
      end
      DRAIN: begin
        if (!eng_out_st)
          state_next = IDLE;
        else if (j_reg == RES_LAST)
          state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      k_reg           <= '0;
      j_reg           <= '0;
      wait_cnt_reg    <= '0;
      rd_vld_reg      <= 1'b0;
      eng_din_reg     <= '0;
      eng_din_vld_reg <= 1'b0;
      wr_en_reg       <= 1'b0;
      wr_addr_reg     <= '0;
      wr_data_reg     <= '0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      frame_cnt_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      rd_vld_reg      <= load_rd;
      eng_din_vld_reg <= rd_vld_reg;
      eng_din_reg     <= rd_vld_reg ? rd_data : 8'd0;
      wr_en_reg       <= sample;
      done_reg        <= (state_reg == FIN);
      err_reg         <= wait_timeout || drain_short;

      if (sample) begin
        wr_addr_reg <= OUT_ADDR0 + ADDR_W'(j_reg);
        wr_data_reg <= eng_dout;
        j_reg       <= j_reg + 6'd1;
      end

      if (state_reg == FIN)
        frame_cnt_reg <= frame_cnt_reg + 16'd1;

      case (state_reg)
        IDLE: begin
          if (start) begin
            k_reg <= '0;
            j_reg <= '0;
          end
        end
        LOAD: begin
          k_reg        <= k_reg + 7'd1;
          wait_cnt_reg <= '0;
        end
        WAIT: begin
          if (!eng_out_st)
            wait_cnt_reg <= wait_cnt_reg + TW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign err         = err_reg;
  assign frame_cnt   = frame_cnt_reg;
  assign rd_en       = load_rd;
  assign rd_addr     = load_rd ? (IN_ADDR0 + ADDR_W'(k_reg)) : '0;
  assign eng_in_st   = (state_reg == LOAD) && (k_reg == 7'd0);
  assign eng_din     = eng_din_reg;
  assign eng_din_vld = eng_din_vld_reg;
  assign wr_en       = wr_en_reg;
  assign wr_addr     = wr_addr_reg;
  assign wr_data     = wr_data_reg;

endmodule

// File: tb/tb_conv_frame_sched.sv
// Randomized bench for conv_frame_sched with a frame-level reference model
// (expected reads, pixels, writes and end-of-frame pulses per frame).
module tb_conv_frame_sched;

  localparam int ADDR_W   = 10;
  localparam int IN_BASE  = 256;
  localparam int OUT_BASE = 512;
  localparam int TIMEOUT  = 20;
  localparam int AMOD     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic              err;
  logic [15:0]       frame_cnt;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              eng_in_st;
  logic [7:0]        eng_din;
  logic              eng_din_vld;
  logic [15:0]       eng_dout;
  logic              eng_out_st;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  always #5 clk = ~clk;

  conv_frame_sched #(
    .ADDR_W  (ADDR_W),
    .IN_BASE (IN_BASE),
    .OUT_BASE(OUT_BASE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .frame_cnt  (frame_cnt),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .eng_in_st  (eng_in_st),
    .eng_din    (eng_din),
    .eng_din_vld(eng_din_vld),
    .eng_dout   (eng_dout),
    .eng_out_st (eng_out_st),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_frames = 0;

  logic [7:0] mem [0:AMOD-1];

  int rd_addr_q[$];
  int rd_cyc_q[$];
  int din_q[$];
  int din_cyc_q[$];
  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_cyc_q[$];
  int inst_cnt, inst_cyc, done_cnt, done_cyc, err_cnt, err_cyc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    din_q.delete();
    din_cyc_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    inst_cnt = 0; inst_cyc = -1;
    done_cnt = 0; done_cyc = -1;
    err_cnt  = 0; err_cyc  = -1;
  endtask

  // Input RAM: data for a read strobed in cycle t is presented during cycle t+1.
  logic              ram_re;
  logic [ADDR_W-1:0] ram_ra;
  initial begin
    rd_data = '0;
    forever begin
      @(negedge clk);
      ram_re = rd_en;
      ram_ra = rd_addr;
      @(posedge clk);
      #1;
      rd_data = ram_re ? mem[ram_ra] : 8'($urandom);
    end
  end

  // Monitor: one cycle number per negedge, transactions logged with it.
  initial begin
    clear_mon();
    forever begin
      @(negedge clk);
      cyc++;
      if (rd_en) begin
        rd_addr_q.push_back(int'(rd_addr));
        rd_cyc_q.push_back(cyc);
      end
      if (eng_din_vld) begin
        din_q.push_back(int'(eng_din));
        din_cyc_q.push_back(cyc);
      end
      if (wr_en) begin
        wr_addr_q.push_back(int'(wr_addr));
        wr_data_q.push_back(int'(wr_data));
        wr_cyc_q.push_back(cyc);
      end
      if (eng_in_st) begin inst_cnt++; inst_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err) begin err_cnt++; err_cyc = cyc; end
      if (done || err) begin
        check_val("done_err_excl", 32'(done & err), 0);
        check_val("busy_at_end", 32'(busy), 0);
      end
      if (rd_en || wr_en)
        check_val("rd_wr_excl", 32'(rd_en & wr_en), 0);
    end
  end

  // mode 0: full drain (nsamp >= 36), 1: short drain, 2: engine never answers.
  task automatic run_frame(input int mode, input int nsamp, input int lat, input bit noisy);
    int  res[$];
    int  f, s, w0, nw, last_start, bound, si;
    bit  seen, load_ok, ended;
    for (int i = 0; i < nsamp; i++) res.push_back(int'($urandom_range(0, 65535)));
    clear_mon();
    @(posedge clk);
    #1;
    start = 1'b1;
    f  = cyc + 2;
    w0 = f + 66;
    seen = 1'b0;
    load_ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (eng_din_vld) seen = 1'b1;
      else if (seen) begin load_ok = 1'b1; break; end
      start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    check_val("load_bound", 32'(load_ok), 1);

    last_start = (mode == 0) ? 36 : nsamp;
    bound = (mode == 2) ? TIMEOUT + 8 : lat + 45;
    ended = 1'b0;
    s = -1000;
    for (int i = 0; i < bound; i++) begin
      si = i - lat;
      start = 1'b0;
      if (done || err) ended = 1'b1;
      if (ended && si >= nsamp) break;
      eng_out_st = (mode != 2) && (si >= 0) && (si < nsamp);
      eng_dout = eng_out_st ? 16'(res[si]) : 16'($urandom);
      if (si == 0 && mode != 2) s = cyc + 1;
      if (noisy && mode != 2 && si >= 1 && si <= last_start)
        start = 1'($urandom_range(0, 1));
      tick();
    end
    eng_out_st = 1'b0;
    start = 1'b0;
    @(negedge clk);
    #1;

    if (mode == 0) exp_frames++;
    nw = (mode == 2) ? 0 : ((nsamp < 36) ? nsamp : 36);

    check_val("n_in_st", inst_cnt, 1);
    check_val("in_st_cyc", inst_cyc, f);
    check_val("n_reads", rd_addr_q.size(), 64);
    if (rd_addr_q.size() == 64) begin
      for (int k = 0; k < 64; k++) begin
        check_val("rd_addr", rd_addr_q[k], (IN_BASE + k) % AMOD);
        check_val("rd_cyc", rd_cyc_q[k], f + k);
      end
    end
    check_val("n_pixels", din_q.size(), 64);
    if (din_q.size() == 64) begin
      for (int k = 0; k < 64; k++) begin
        check_val("eng_din", din_q[k], int'(mem[(IN_BASE + k) % AMOD]));
        check_val("din_cyc", din_cyc_q[k], f + 2 + k);
      end
    end
    check_val("n_writes", wr_addr_q.size(), nw);
    if (wr_addr_q.size() == nw) begin
      for (int j = 0; j < nw; j++) begin
        check_val("wr_addr", wr_addr_q[j], (OUT_BASE + j) % AMOD);
        check_val("wr_data", wr_data_q[j], res[j]);
        check_val("wr_cyc", wr_cyc_q[j], s + j + 1);
      end
    end
    if (mode == 0) begin
      check_val("n_done", done_cnt, 1);
      check_val("done_cyc", done_cyc, s + 37);
      check_val("n_err", err_cnt, 0);
    end else if (mode == 1) begin
      check_val("n_err", err_cnt, 1);
      check_val("short_err_cyc", err_cyc, s + nsamp + 1);
      check_val("n_done", done_cnt, 0);
    end else begin
      check_val("n_err", err_cnt, 1);
      check_val("timeout_err_cyc", err_cyc, w0 + TIMEOUT);
      check_val("n_done", done_cnt, 0);
    end
    check_val("frame_cnt", 32'(frame_cnt), exp_frames % 65536);
    check_val("idle_after", 32'(busy), 0);
    $display("frame mode=%0d lat=%0d nsamp=%0d reads=%0d writes=%0d done=%0d err=%0d frame_cnt=%0d",
             mode, lat, nsamp, rd_addr_q.size(), wr_addr_q.size(), done_cnt, err_cnt, frame_cnt);
  endtask

  task automatic reset_mid_frame();
    bit hit;
    hit = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rd_en && int'(rd_addr) == (IN_BASE + 30) % AMOD) begin hit = 1'b1; break; end
      tick();
    end
    check_val("rst_at_k30", 32'(hit), 1);
    rst = 1'b1;
    #1;
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_done", 32'(done), 0);
    check_val("rst_err", 32'(err), 0);
    check_val("rst_frame_cnt", 32'(frame_cnt), 0);
    check_val("rst_rd_en", 32'(rd_en), 0);
    check_val("rst_rd_addr", 32'(rd_addr), 0);
    check_val("rst_eng_in_st", 32'(eng_in_st), 0);
    check_val("rst_eng_din", 32'(eng_din), 0);
    check_val("rst_eng_din_vld", 32'(eng_din_vld), 0);
    check_val("rst_wr_en", 32'(wr_en), 0);
    check_val("rst_wr_addr", 32'(wr_addr), 0);
    check_val("rst_wr_data", 32'(wr_data), 0);
    exp_frames = 0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    check_val("post_rst_busy", 32'(busy), 0);
    check_val("post_rst_wr_en", 32'(wr_en), 0);
    $display("reset applied at read k=30, frame_cnt=%0d", frame_cnt);
  endtask

  initial begin
    int mode, nsamp, lat;
    for (int a = 0; a < AMOD; a++) mem[a] = 8'($urandom);
    rst = 1'b1;
    start = 1'b0;
    eng_out_st = 1'b0;
    eng_dout = '0;
    repeat (3) tick();
    check_val("reset_busy", 32'(busy), 0);
    check_val("reset_rd_en", 32'(rd_en), 0);
    check_val("reset_wr_en", 32'(wr_en), 0);
    check_val("reset_done", 32'(done), 0);
    check_val("reset_frame_cnt", 32'(frame_cnt), 0);
    rst = 1'b0;
    tick();

    run_frame(0, 36, 3, 1'b0);
    run_frame(0, 39, TIMEOUT - 1, 1'b1);
    run_frame(2, 0, 0, 1'b1);
    run_frame(1, 10, 5, 1'b1);
    run_frame(1, 1, 0, 1'b0);
    reset_mid_frame();
    run_frame(0, 36, 0, 1'b0);
    run_frame(0, 36, 2, 1'b0);
    run_frame(0, 36, 7, 1'b0);
    for (int n = 0; n < 8; n++) begin
      mode = int'($urandom_range(0, 2));
      lat = int'($urandom_range(0, TIMEOUT - 1));
      if (mode == 0) nsamp = 36 + int'($urandom_range(0, 3));
      else if (mode == 1) nsamp = int'($urandom_range(1, 35));
      else nsamp = 0;
      run_frame(mode, nsamp, lat, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
